salamander_sndrom_arbiter: RTL
==============================

// Module: salamander_sndrom_arbiter
// PURPOSE
// - Shares one external byte-wide ROM read port (SDRAM bridge) between two requesters:
//   K007232 PCM sample address (req 0) and VLM5030 speech ROM address (req 1).
// - Detects address changes per requester, fetches via a request/ack handshake, and holds
//   the last fetched byte with a match-valid flag.
// - Sits between the sound board PCM/VLM address outputs and the top-level SDRAM port.
// PARAMETERS
// - MEM_AW    18        external ROM address width
// - VLM_BASE  18'h20000 external base address of the VLM region; PCM region base is 0
// - TIMEOUT   8'd255    WAIT cycles before an abort (used only with the macro)
// PORTS
// - i_EMU_MCLK        in   1       sole clock; all logic on posedge
// - i_EMU_INITRST_n   in   1       reset, synchronous, active-low
// - i_PCM_ADDR        in   17      K007232 sample address
// - o_PCM_DATA        out  8       last byte fetched for PCM
// - o_PCM_VALID       out  1       o_PCM_DATA corresponds to the current i_PCM_ADDR
// - i_VLM_ADDR        in   14      VLM5030 ROM address
// - i_VLM_RD          in   1       VLM memory enable (active-high); no fetch while low
// - o_VLM_DATA        out  8       last byte fetched for VLM
// - o_VLM_VALID       out  1       o_VLM_DATA corresponds to the current i_VLM_ADDR
// - o_MEM_ADDR        out  MEM_AW  external read address; held stable from ISSUE through WAIT
// - o_MEM_RDRQ        out  1       one-cycle read strobe
// - i_MEM_DATA        in   8       read data; sampled on i_MEM_ACK
// - i_MEM_ACK         in   1       one-cycle data-valid strobe
// - o_TIMEOUT         out  1       sticky abort flag
// BEHAVIOUR
// - Reset values: FSM=IDLE, o_MEM_RDRQ=0, o_MEM_ADDR=0, o_*_DATA=8'hFF, tag_valid0/1=0,
//   last_grant=1 (PCM wins first), o_TIMEOUT=0, timeout counter=0.
// - Per-requester tag register holds the address of the stored byte.
// - need0 = ~tag_valid0 | (i_PCM_ADDR != tag0)
// - need1 = i_VLM_RD & (~tag_valid1 | (i_VLM_ADDR != tag1))
// - o_X_VALID = tag_validX & (i_X_ADDR == tagX); combinational. Data outputs are registered.
// - FSM:
//   - IDLE -> ISSUE when need0|need1.
//     - Round-robin grant: if both need, grant the requester that is not last_grant.
//     - Latch the granted address into o_MEM_ADDR: PCM -> zero-extended i_PCM_ADDR;
//       VLM -> VLM_BASE + i_VLM_ADDR.
//     - Latch the requester address into an internal fetch-address register.
//   - ISSUE -> WAIT: o_MEM_RDRQ=1 for exactly this cycle; clear the timeout counter.
//   - WAIT -> IDLE on i_MEM_ACK:
//     - data_X <= i_MEM_DATA; tagX <= fetch-address; tag_validX <= 1; last_grant <= X.
// - i_MEM_ACK outside WAIT (incl. in ISSUE) is ignored.
// - Minimum cost is 3 cycles per fetch (IDLE, ISSUE, WAIT with ACK).
//   o_X_VALID rises the cycle after ACK.
// - Address changes mid-fetch: the fetch completes with the old address tagged.
//   The mismatch re-raises need, so a refetch follows; no data is dropped or mis-tagged.
// - ACK and a new need in the same cycle: complete the ACK; arbitrate next cycle in IDLE.
// - i_VLM_RD falling during a VLM fetch: the fetch still completes.
// - Reset asserted mid-operation: return to IDLE on that edge; a late ACK is ignored.
// - Widths: VLM_BASE + i_VLM_ADDR is computed in MEM_AW bits; overflow wraps (a config error).
// CONFIGURATION
// - Macro SALAMANDER_SNDROM_TIMEOUT_EN.
//   - Defined:
//     - In WAIT the counter increments each cycle without ACK.
//     - When the count reaches TIMEOUT: data_X <= 8'hFF, tag the fetch address valid
//       (no retry storm), o_TIMEOUT <= 1 (sticky until reset), go to IDLE.
//     - ACK in the same cycle as the limit wins; no abort.
//   - Undefined: WAIT lasts until ACK indefinitely; o_TIMEOUT tied 0; no counter logic.
// TESTING
// - Reset release, i_PCM_ADDR=17'h00123, i_VLM_RD=0 -> RDRQ two cycles later with
//   o_MEM_ADDR=18'h00123; ACK with 8'h5A -> o_PCM_DATA=8'h5A, o_PCM_VALID=1 next cycle.
// - Both need at once (PCM 17'h00010, VLM 14'h0004, RD=1) -> first fetch 18'h00010,
//   second 18'h20004; repeat both changing -> grants alternate PCM, VLM, PCM.
// - PCM addr 17'h00001 -> 17'h00002 in WAIT -> ACK tags 00001 with o_PCM_VALID=0;
//   a new RDRQ for 18'h00002 follows; VALID=1 after its ACK.
// - Spurious ACK in IDLE/ISSUE -> no data or tag change. Reset asserted in WAIT ->
//   FSM=IDLE, data=8'hFF, both VALID=0.
// - With SALAMANDER_SNDROM_TIMEOUT_EN, TIMEOUT=8: withhold ACK -> 8 WAIT cycles later
//   o_PCM_DATA=8'hFF, o_TIMEOUT=1, no further RDRQ for that address.
//   Without the macro: still in WAIT at 1000 cycles.
// - Hold i_PCM_ADDR constant, VLM RD=0 -> no RDRQ after the first fetch; raise RD with a
//   new VLM addr -> exactly one RDRQ.

Source files
------------

// File: rtl/salamander_sndrom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : salamander_sndrom_arbiter
// Purpose  : Shares one byte-wide external ROM read port between the K007232
//            PCM sample address (requester 0) and the VLM5030 speech ROM
//            address (requester 1). Each requester keeps a one-byte cache
//            tagged with the address it was fetched for; a tag miss raises a
//            fetch through a request/ack handshake with round-robin grant.
// Options  : `define SALAMANDER_SNDROM_TIMEOUT_EN enables the WAIT-state
//            abort counter and the sticky o_TIMEOUT flag.
// Revision : 1.0 - initial release
// ============================================================================
module salamander_sndrom_arbiter #(
    parameter int                MEM_AW   = 18,
    parameter logic [MEM_AW-1:0] VLM_BASE = 18'h20000,
    parameter logic [7:0]        TIMEOUT  = 8'd255
) (
    input  logic              i_EMU_MCLK,
    input  logic              i_EMU_INITRST_n,

    input  logic [16:0]       i_PCM_ADDR,
    output logic [7:0]        o_PCM_DATA,
    output logic              o_PCM_VALID,

    input  logic [13:0]       i_VLM_ADDR,
    input  logic              i_VLM_RD,
    output logic [7:0]        o_VLM_DATA,
    output logic              o_VLM_VALID,

    output logic [MEM_AW-1:0] o_MEM_ADDR,
    output logic              o_MEM_RDRQ,
    input  logic [7:0]        i_MEM_DATA,
    input  logic              i_MEM_ACK,

    output logic              o_TIMEOUT
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic c_GRANT_PCM = 1'b0;
    localparam logic c_GRANT_VLM = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [MEM_AW-1:0] r_mem_addr;
    logic              r_mem_rdrq;
    logic              r_grant;        // requester owning the fetch in flight
    logic              r_last_grant;   // requester served by the last fetch
    logic [16:0]       r_fetch_addr;   // requester-side address of the fetch

    logic [7:0]        r_pcm_data;
    logic [16:0]       r_tag0;
    logic              r_tag_valid0;

    logic [7:0]        r_vlm_data;
    logic [13:0]       r_tag1;
    logic              r_tag_valid1;

`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
    logic [7:0]        r_to_cnt;
    logic              r_timeout;
`endif

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic              w_need0;
    logic              w_need1;
    logic              w_grant;
    logic [MEM_AW-1:0] w_pcm_mem_addr;
    logic [MEM_AW-1:0] w_vlm_mem_addr;
    logic              w_wait_done;
    logic [7:0]        w_fill_data;

    // A requester needs a fetch when its cached byte does not belong to its
    // current address; VLM only asks while its memory enable is high.
    assign w_need0 = ~r_tag_valid0 | (i_PCM_ADDR != r_tag0);
    assign w_need1 = i_VLM_RD & (~r_tag_valid1 | (i_VLM_ADDR != r_tag1));

    // Round-robin only matters on a tie; otherwise the sole requester wins.
    assign w_grant = (w_need0 & w_need1) ? ~r_last_grant : w_need1;

    // PCM region starts at zero; VLM region is offset and wraps in MEM_AW bits.
    assign w_pcm_mem_addr = MEM_AW'(i_PCM_ADDR);
    assign w_vlm_mem_addr = VLM_BASE + MEM_AW'(i_VLM_ADDR);

    // The cache outputs compare live addresses against the stored tag.
    assign o_PCM_VALID = r_tag_valid0 & (i_PCM_ADDR == r_tag0);
    assign o_VLM_VALID = r_tag_valid1 & (i_VLM_ADDR == r_tag1);

    assign o_PCM_DATA  = r_pcm_data;
    assign o_VLM_DATA  = r_vlm_data;
    assign o_MEM_ADDR  = r_mem_addr;
    assign o_MEM_RDRQ  = r_mem_rdrq;

`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
    // ACK on the limit cycle takes priority, so the real byte is kept.
    assign w_wait_done = i_MEM_ACK | (r_to_cnt == 8'(TIMEOUT - 8'd1));
    assign w_fill_data = i_MEM_ACK ? i_MEM_DATA : 8'hFF;
    assign o_TIMEOUT   = r_timeout;
`else
    assign w_wait_done = i_MEM_ACK;
    assign w_fill_data = i_MEM_DATA;
    assign o_TIMEOUT   = 1'b0;
    wire [7:0] w_unused_timeout = TIMEOUT;
`endif

    // ------------------------------------------------------------------------
    // Fetch sequencer: arbitrate in IDLE, strobe in ISSUE, collect in WAIT.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_EMU_MCLK) begin
        if (!i_EMU_INITRST_n) begin
            r_state      <= ST_IDLE;
            r_mem_addr   <= '0;
            r_mem_rdrq   <= 1'b0;
            r_grant      <= c_GRANT_PCM;
            r_last_grant <= c_GRANT_VLM;
            r_fetch_addr <= '0;
            r_pcm_data   <= 8'hFF;
            r_tag0       <= '0;
            r_tag_valid0 <= 1'b0;
            r_vlm_data   <= 8'hFF;
            r_tag1       <= '0;
            r_tag_valid1 <= 1'b0;
`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
            r_to_cnt     <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_mem_rdrq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_need0 | w_need1) begin
                        r_state    <= ST_ISSUE;
                        r_mem_rdrq <= 1'b1;
                        r_grant    <= w_grant;
                        if (w_grant == c_GRANT_VLM) begin
                            r_mem_addr   <= w_vlm_mem_addr;
                            r_fetch_addr <= {3'b000, i_VLM_ADDR};
                        end else begin
                            r_mem_addr   <= w_pcm_mem_addr;
                            r_fetch_addr <= i_PCM_ADDR;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Any ACK seen here precedes our strobe and is ignored.
                    r_state <= ST_WAIT;
`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end

                ST_WAIT: begin
                    if (w_wait_done) begin
                        // The tag is the address the fetch was issued for, so
                        // a mid-fetch address change shows as a miss and
                        // triggers a refetch rather than a mis-tagged byte.
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                        if (r_grant == c_GRANT_VLM) begin
                            r_vlm_data   <= w_fill_data;
                            r_tag1       <= r_fetch_addr[13:0];
                            r_tag_valid1 <= 1'b1;
                        end else begin
                            r_pcm_data   <= w_fill_data;
                            r_tag0       <= r_fetch_addr;
                            r_tag_valid0 <= 1'b1;
                        end
`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
                        if (!i_MEM_ACK) begin
                            r_timeout <= 1'b1;
                        end
`endif
                    end
`ifdef SALAMANDER_SNDROM_TIMEOUT_EN
                    else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
